ntt_scheduler: RTL and testbench

NTT_SCHEDULER -- requirements
Module: ntt_scheduler

---
 rtl/ntt_scheduler_if.sv | 42 ++++
 rtl/ntt_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_ntt_scheduler.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ntt_scheduler_if.sv
// Handshake and address bundle between the NTT scheduler and its core/router datapath.
// The master side requests runs; the slave side (the scheduler) drives read/write/readout addressing.
interface ntt_scheduler_if #(
   parameter int LOG_N          = 12,
   parameter int LOG_CORE_COUNT = 5
);
   localparam int D  = LOG_N - 1 - LOG_CORE_COUNT;
   localparam int LW = $clog2(LOG_N + 1);

   logic          start;
   logic          inv;
   logic          abort;
   logic          busy;
   logic          done;
   logic          rd_valid;
   logic [D-1:0]  rd_addr_even;
   logic [D-1:0]  rd_addr_odd;
   logic          rd_bank;
   logic [LW-1:0] log_m;
   logic [LW-1:0] log_t;
   logic [D-1:0]  grp;
   logic          wr_en;
   logic [D-1:0]  wr_addr_even;
   logic [D-1:0]  wr_addr_odd;
   logic          wr_bank;
   logic [LW-1:0] wr_log_m;
   logic [LW-1:0] wr_log_t;
   logic          out_valid;
   logic [D-1:0]  out_addr;

   modport master (
      output start, inv, abort,
      input  busy, done, rd_valid, rd_addr_even, rd_addr_odd, rd_bank, log_m, log_t, grp,
      input  wr_en, wr_addr_even, wr_addr_odd, wr_bank, wr_log_m, wr_log_t, out_valid, out_addr
   );

   modport slave (
      input  start, inv, abort,
      output busy, done, rd_valid, rd_addr_even, rd_addr_odd, rd_bank, log_m, log_t, grp,
      output wr_en, wr_addr_even, wr_addr_odd, wr_bank, wr_log_m, wr_log_t, out_valid, out_addr
   );
endinterface

// File: rtl/ntt_scheduler.sv
// Stage/address sequencer for a banked NTT: drives per-core butterfly reads, a delayed write
// stream matched to the datapath latency, and a final readout sweep.
//
// state   | meaning
// IDLE    | waiting for start; done pulses here for one cycle after a run
// COMPUTE | LOG_N stages of J read beats each, back to back
// DRAIN   | PIPE_STAGES cycles with no reads while the datapath empties
// OUTPUT  | J readout beats from the final bank
module ntt_scheduler #(
   parameter int LOG_N          = 12,
   parameter int LOG_CORE_COUNT = 5,
   parameter int PIPE_STAGES    = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   ntt_scheduler_if.slave   bus
);
   localparam int D  = LOG_N - 1 - LOG_CORE_COUNT;
   localparam int J  = 2 ** D;
   localparam int LW = $clog2(LOG_N + 1);
   localparam int CW = $clog2(PIPE_STAGES + 1);
   localparam logic FINAL_BANK = 1'(LOG_N % 2);

   if (D < 1 || PIPE_STAGES < 1) begin : g_bad_params
      $error("ntt_scheduler: need LOG_N-1-LOG_CORE_COUNT >= 1 and PIPE_STAGES >= 1");
   end

   typedef enum logic [1:0] {IDLE, COMPUTE, DRAIN, OUTPUT} state_t;

   typedef struct packed {
      logic          valid;
      logic [D-1:0]  even;
      logic [D-1:0]  odd;
      logic          bank;
      logic [LW-1:0] lm;
      logic [LW-1:0] lt;
   } wr_t;

   state_t        state, nxt_state;
   logic [LW-1:0] s, nxt_s;
   logic [D-1:0]  idx, nxt_idx;
   logic [CW-1:0] cnt, nxt_cnt;
   logic          inv_q, nxt_inv;
   logic          fin;

   logic [LW-1:0] lt;
   logic [D-1:0]  tmask, half, a_even, a_odd, a_grp;

   logic          busy_q, done_q, rd_valid_q, rd_bank_q, out_valid_q;
   logic [D-1:0]  even_q, odd_q, grp_q, out_addr_q;
   logic [LW-1:0] log_m_q, log_t_q;

   wr_t           entry;
   wr_t           pipe [PIPE_STAGES];

   always_comb begin
      nxt_state = state;
      nxt_s     = s;
      nxt_idx   = idx;
      nxt_cnt   = cnt;
      nxt_inv   = inv_q;
      fin       = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               nxt_state = COMPUTE;
               nxt_s     = '0;
               nxt_idx   = '0;
               nxt_inv   = bus.inv;
            end
         end
         COMPUTE: begin
            if (idx == D'(J - 1)) begin
               nxt_idx = '0;
               if (s == LW'(LOG_N - 1)) begin
                  nxt_state = DRAIN;
                  nxt_cnt   = CW'(PIPE_STAGES - 1);
               end else begin
                  nxt_s = s + LW'(1);
               end
            end else begin
               nxt_idx = idx + D'(1);
            end
         end
         DRAIN: begin
            if (cnt == '0) begin
               nxt_state = OUTPUT;
               nxt_idx   = '0;
            end else begin
               nxt_cnt = cnt - CW'(1);
            end
         end
         OUTPUT: begin
            if (idx == D'(J - 1)) begin
               nxt_state = IDLE;
               fin       = 1'b1;
            end else begin
               nxt_idx = idx + D'(1);
            end
         end
         default: nxt_state = IDLE;
      endcase
      // abort beats everything, including a same-cycle start in IDLE
      if (bus.abort) begin
         nxt_state = IDLE;
         fin       = 1'b0;
      end
   end

   // Groups of T = 2^lt are contiguous in idx, so even is idx itself and odd rotates within the group.
   always_comb begin
      lt     = nxt_inv ? nxt_s : LW'(LOG_N - 1) - nxt_s;
      tmask  = '0;
      half   = '0;
      for (int b = 0; b < D; b++) begin
         tmask[b] = (b < int'(lt));
         half[b]  = (b + 1 == int'(lt));
      end
      a_even = nxt_idx;
      a_odd  = nxt_idx;
      a_grp  = '0;
      if (int'(lt) < D) begin
         a_odd = (nxt_idx & ~tmask) | ((nxt_idx + half) & tmask);
         a_grp = nxt_idx >> lt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         s           <= '0;
         idx         <= '0;
         cnt         <= '0;
         inv_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rd_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_addr_q  <= '0;
         even_q      <= '0;
         odd_q       <= '0;
         grp_q       <= '0;
         log_t_q     <= '0;
         log_m_q     <= '0;
         rd_bank_q   <= 1'b0;
      end else begin
         state       <= nxt_state;
         s           <= nxt_s;
         idx         <= nxt_idx;
         cnt         <= nxt_cnt;
         inv_q       <= nxt_inv;
         busy_q      <= (nxt_state != IDLE);
         done_q      <= fin;
         rd_valid_q  <= (nxt_state == COMPUTE);
         out_valid_q <= (nxt_state == OUTPUT);
         out_addr_q  <= (nxt_state == OUTPUT) ? nxt_idx : '0;
         if (nxt_state == COMPUTE) begin
            even_q    <= a_even;
            odd_q     <= a_odd;
            grp_q     <= a_grp;
            log_t_q   <= lt;
            log_m_q   <= LW'(LOG_N - 1) - lt;
            rd_bank_q <= nxt_s[0];
         end else begin
            even_q    <= '0;
            odd_q     <= '0;
            grp_q     <= '0;
            log_t_q   <= '0;
            log_m_q   <= '0;
            rd_bank_q <= (nxt_state == OUTPUT || nxt_state == DRAIN) ? FINAL_BANK : 1'b0;
         end
      end
   end

   always_comb begin
      entry       = '0;
      entry.valid = rd_valid_q;
      entry.even  = even_q;
      entry.odd   = odd_q;
      entry.bank  = rd_valid_q & ~rd_bank_q;
      entry.lm    = log_m_q;
      entry.lt    = log_t_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < PIPE_STAGES; i++) pipe[i] <= '0;
      end else if (bus.abort) begin
         for (int i = 0; i < PIPE_STAGES; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= entry;
         for (int i = 1; i < PIPE_STAGES; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.rd_valid     = rd_valid_q;
   assign bus.rd_addr_even = even_q;
   assign bus.rd_addr_odd  = odd_q;
   assign bus.rd_bank      = rd_bank_q;
   assign bus.log_m        = log_m_q;
   assign bus.log_t        = log_t_q;
   assign bus.grp          = grp_q;
   assign bus.wr_en        = pipe[PIPE_STAGES-1].valid;
   assign bus.wr_addr_even = pipe[PIPE_STAGES-1].even;
   assign bus.wr_addr_odd  = pipe[PIPE_STAGES-1].odd;
   assign bus.wr_bank      = pipe[PIPE_STAGES-1].bank;
   assign bus.wr_log_m     = pipe[PIPE_STAGES-1].lm;
   assign bus.wr_log_t     = pipe[PIPE_STAGES-1].lt;
   assign bus.out_valid    = out_valid_q;
   assign bus.out_addr     = out_addr_q;
endmodule

// File: tb/tb_ntt_scheduler.sv
// Bench for ntt_scheduler: default-size instance checked cycle by cycle against a stage/group model,
// plus a small instance run back to back with start held high.
module tb_ntt_scheduler;
   localparam int LN   = 12;
   localparam int LC   = 5;
   localparam int P    = 10;
   localparam int D    = LN - 1 - LC;
   localparam int J    = 1 << D;
   localparam int NC   = LN * J;
   localparam int LAT  = NC + P + J + 1;
   localparam int SLN  = 4;
   localparam int SLC  = 1;
   localparam int SD   = SLN - 1 - SLC;
   localparam int SJ   = 1 << SD;
   localparam int SLAT = SLN * SJ + P + SJ + 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cur_k  = 0;

   always #5 clk = ~clk;

   ntt_scheduler_if #(.LOG_N(LN), .LOG_CORE_COUNT(LC)) bus ();
   ntt_scheduler_if #(.LOG_N(SLN), .LOG_CORE_COUNT(SLC)) bus_s ();

   ntt_scheduler #(.LOG_N(LN), .LOG_CORE_COUNT(LC), .PIPE_STAGES(P)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );
   ntt_scheduler #(.LOG_N(SLN), .LOG_CORE_COUNT(SLC), .PIPE_STAGES(P)) dut_s (
      .clk(clk), .rst_n(rst_n), .bus(bus_s)
   );

   typedef struct packed {
      bit        busy;
      bit        done;
      bit        rdv;
      bit        bank;
      bit        outv;
      bit [15:0] even;
      bit [15:0] odd;
      bit [15:0] grp;
      bit [15:0] lm;
      bit [15:0] lt;
      bit [15:0] oa;
   } exp_t;

   // Expected outputs k cycles after the acceptance edge, straight from the stage/group rules.
   function automatic exp_t model(int k, bit dir_inv, int logn, int d, int p);
      exp_t e;
      int jn, nc, s, i, lt, t, g, j;
      e  = '0;
      jn = 1 << d;
      nc = logn * jn;
      if (k < 0) return e;
      if (k < nc) begin
         s      = k / jn;
         i      = k % jn;
         lt     = dir_inv ? s : logn - 1 - s;
         e.busy = 1'b1;
         e.rdv  = 1'b1;
         e.bank = 1'(s % 2);
         e.lt   = 16'(lt);
         e.lm   = 16'(logn - 1 - lt);
         if (lt >= d) begin
            e.even = 16'(i);
            e.odd  = 16'(i);
         end else begin
            t      = 1 << lt;
            g      = i / t;
            j      = i % t;
            e.even = 16'(g * t + j);
            e.odd  = 16'(g * t + (j + t / 2) % t);
            e.grp  = 16'(g);
         end
      end else if (k < nc + p) begin
         e.busy = 1'b1;
      end else if (k < nc + p + jn) begin
         e.busy = 1'b1;
         e.outv = 1'b1;
         e.oa   = 16'(k - nc - p);
         e.bank = 1'(logn % 2);
      end else if (k == nc + p + jn) begin
         e.done = 1'b1;
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s k=%0d observed=%0d expected=%0d", tag, cur_k, obs, exp);
      end
   endtask

   task automatic check_big(input int k, input bit dir);
      exp_t m, w;
      cur_k = k;
      m = model(k, dir, LN, D, P);
      w = model(k - P, dir, LN, D, P);
      chk("busy",      32'(bus.busy),      32'(m.busy));
      chk("done",      32'(bus.done),      32'(m.done));
      chk("rd_valid",  32'(bus.rd_valid),  32'(m.rdv));
      chk("out_valid", 32'(bus.out_valid), 32'(m.outv));
      chk("wr_en",     32'(bus.wr_en),     32'(w.rdv));
      if (m.rdv) begin
         chk("rd_even", 32'(bus.rd_addr_even), 32'(m.even));
         chk("rd_odd",  32'(bus.rd_addr_odd),  32'(m.odd));
         chk("grp",     32'(bus.grp),          32'(m.grp));
         chk("log_t",   32'(bus.log_t),        32'(m.lt));
         chk("log_m",   32'(bus.log_m),        32'(m.lm));
         chk("rd_bank", 32'(bus.rd_bank),      32'(m.bank));
      end
      if (m.outv) begin
         chk("out_addr", 32'(bus.out_addr), 32'(m.oa));
         chk("out_bank", 32'(bus.rd_bank),  32'(m.bank));
      end
      if (w.rdv) begin
         chk("wr_even",  32'(bus.wr_addr_even), 32'(w.even));
         chk("wr_odd",   32'(bus.wr_addr_odd),  32'(w.odd));
         chk("wr_bank",  32'(bus.wr_bank),      32'(!w.bank));
         chk("wr_log_m", 32'(bus.wr_log_m),     32'(w.lm));
         chk("wr_log_t", 32'(bus.wr_log_t),     32'(w.lt));
      end
   endtask

   task automatic accept(input bit dir);
      bus.start = 1'b1;
      bus.inv   = dir;
      @(negedge clk);
      bus.start = 1'b0;
      bus.inv   = 1'($urandom);
   endtask

   // Checks cycles 0..k_last after acceptance; at k_poke pulses start with flipped inv mid-run.
   task automatic check_span(input bit dir, input int k_last, input int k_poke,
                             output int kd, output int nrd);
      kd  = -1;
      nrd = 0;
      for (int k = 0; k <= k_last; k++) begin
         if (k > 0) @(negedge clk);
         bus.start = 1'b0;
         check_big(k, dir);
         if (bus.done === 1'b1 && kd < 0) kd = k;
         if (bus.rd_valid === 1'b1) nrd++;
         if (k == k_poke) begin
            bus.start = 1'b1;
            bus.inv   = ~dir;
         end
      end
      bus.start = 1'b0;
   endtask

   task automatic full_run(input bit dir, input int k_poke);
      int kd, nrd;
      accept(dir);
      check_span(dir, LAT, k_poke, kd, nrd);
      chk("latency",   32'(kd + 1), 32'(LAT));
      chk("rd_cycles", 32'(nrd),    32'(NC));
   endtask

   initial begin
      int   kd, nrd, ka, kr, ndone;
      bit   dir;
      exp_t m, w;
      bus.start   = 1'b0; bus.inv   = 1'b0; bus.abort   = 1'b0;
      bus_s.start = 1'b0; bus_s.inv = 1'b0; bus_s.abort = 1'b0;

      @(negedge clk);
      cur_k = -1;
      chk("rst_busy",      32'(bus.busy),      32'd0);
      chk("rst_rd_valid",  32'(bus.rd_valid),  32'd0);
      chk("rst_wr_en",     32'(bus.wr_en),     32'd0);
      chk("rst_done",      32'(bus.done),      32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_s_busy",    32'(bus_s.busy),    32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_busy", 32'(bus.busy), 32'd0);

      bus.start = 1'b1;
      bus.abort = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      chk("abort_start_busy",     32'(bus.busy),     32'd0);
      chk("abort_start_rd_valid", 32'(bus.rd_valid), 32'd0);
      @(negedge clk);

      full_run(1'b0, -1);
      full_run(1'b1, $urandom_range(1, 800));
      full_run(1'($urandom), $urandom_range(1, 800));

      dir = 1'($urandom);
      accept(dir);
      ka = 3 * J + $urandom_range(0, J - 1);
      check_span(dir, ka, -1, kd, nrd);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      cur_k = ka + 1;
      chk("abort_busy",      32'(bus.busy),      32'd0);
      chk("abort_rd_valid",  32'(bus.rd_valid),  32'd0);
      chk("abort_wr_en",     32'(bus.wr_en),     32'd0);
      chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
      chk("abort_done",      32'(bus.done),      32'd0);
      ndone = 0;
      for (int i = 0; i < LAT; i++) begin
         @(negedge clk);
         if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.wr_en !== 1'b0) ndone++;
      end
      chk("abort_quiet", 32'(ndone), 32'd0);

      full_run(1'($urandom), -1);

      dir = 1'($urandom);
      accept(dir);
      kr = NC + $urandom_range(1, 6);
      check_span(dir, kr, -1, kd, nrd);
      #2 rst_n = 1'b0;
      #1;
      cur_k = kr;
      chk("rst_mid_busy",      32'(bus.busy),         32'd0);
      chk("rst_mid_rd_valid",  32'(bus.rd_valid),     32'd0);
      chk("rst_mid_wr_en",     32'(bus.wr_en),        32'd0);
      chk("rst_mid_wr_bank",   32'(bus.wr_bank),      32'd0);
      chk("rst_mid_wr_even",   32'(bus.wr_addr_even), 32'd0);
      chk("rst_mid_wr_log_t",  32'(bus.wr_log_t),     32'd0);
      chk("rst_mid_rd_bank",   32'(bus.rd_bank),      32'd0);
      chk("rst_mid_out_valid", 32'(bus.out_valid),    32'd0);
      chk("rst_mid_done",      32'(bus.done),         32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (bus.busy !== 1'b0) ndone++;
      end
      chk("rst_release_idle", 32'(ndone), 32'd0);

      full_run(1'($urandom), -1);

      bus_s.start = 1'b1;
      @(negedge clk);
      ndone = 0;
      for (int k = 0; k <= 3 * SLAT + 1; k++) begin
         if (k > 0) @(negedge clk);
         cur_k = k;
         m = model(k % SLAT, 1'b0, SLN, SD, P);
         w = model(k % SLAT - P, 1'b0, SLN, SD, P);
         chk("s_busy",     32'(bus_s.busy),     32'(m.busy));
         chk("s_done",     32'(bus_s.done),     32'(m.done));
         chk("s_rd_valid", 32'(bus_s.rd_valid), 32'(m.rdv));
         chk("s_wr_en",    32'(bus_s.wr_en),    32'(w.rdv));
         if (m.rdv) chk("s_rd_odd", 32'(bus_s.rd_addr_odd), 32'(m.odd));
         if (bus_s.done === 1'b1) ndone++;
      end
      bus_s.start = 1'b0;
      chk("s_done_count", 32'(ndone), 32'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
